// File: rtl/game_pkg.sv
// Shared definitions for the game controller: FSM state encoding, field widths
// and a small max helper used when latching the high score.
package game_pkg;
  localparam int LIVES_W = 3;
  localparam int SCORE_W = 8;

  typedef enum logic [2:0] {
    ATTRACT = 3'd0,
    READY   = 3'd1,
    PLAY    = 3'd2,
    DYING   = 3'd3,
    WAVE    = 3'd4,
    OVER    = 3'd5
  } state_t;

  function automatic logic [SCORE_W-1:0] max3(input logic [SCORE_W-1:0] a,
                                              input logic [SCORE_W-1:0] b,
                                              input logic [SCORE_W-1:0] c);
    logic [SCORE_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/game_controller_pause_timer.sv
// Frame-tick pause counter: held at zero while start is low, done fires on the
// PAUSE_FRAMES-th tick and the count restarts so back-to-back pauses work.
module pause_timer #(
  parameter int PAUSE_FRAMES = 60
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic start,
  input  logic frame_tick,
  output logic done
);
  logic [7:0] count;

  assign done = start && frame_tick && (count == 8'(PAUSE_FRAMES - 1));

  always_ff @(posedge clk_36MHz) begin
    if (!reset)
      count <= '0;
    else if (!start || done)
      count <= '0;
    else if (frame_tick)
      count <= count + 8'd1;
  end
endmodule

// File: rtl/game_controller.sv
// Game flow controller: attract/ready/play/dying/wave/over sequencing, lives,
// scores and high score. Define TWO_PLAYER_EN for alternating two-player games.
module game_controller
  import game_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic               clk_36MHz,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_debounced,
  input  logic               hit,
  input  logic               ship_hit,
  input  logic               wave_cleared,
  output logic               enable,
  output logic               clear,
  output logic               clear_score,
  output logic               active_player,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score_p0,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] hi_score
);
  state_t             state_q;
  logic [LIVES_W-1:0] lives_p0;
  logic [LIVES_W-1:0] lives_p1;
  logic [SCORE_W-1:0] hi_q = '0;
  logic               timing;
  logic               done;
  logic               p1_alive;
  logic               go_over;

  assign timing = (state_q == READY) || (state_q == DYING) ||
                  (state_q == WAVE)  || (state_q == OVER);

  pause_timer #(.PAUSE_FRAMES(PAUSE_FRAMES)) u_timer (
    .clk_36MHz  (clk_36MHz),
    .reset      (reset),
    .start      (timing),
    .frame_tick (frame_tick),
    .done       (done)
  );

`ifdef TWO_PLAYER_EN
  logic other_alive;
  assign p1_alive    = (lives_p1 != '0);
  assign other_alive = active_player ? (lives_p0 != '0) : p1_alive;
`else
  assign p1_alive = 1'b0;
`endif

  assign go_over  = (state_q == DYING) && done && (lives_p0 == '0) && !p1_alive;
  assign state    = state_q;
  assign lives    = active_player ? lives_p1 : lives_p0;
  assign hi_score = hi_q;

  // High score survives reset; it only starts from zero at power-up.
  always_ff @(posedge clk_36MHz) begin
    if (reset && go_over)
      hi_q <= max3(hi_q, score_p0, score_p1);
  end

  always_ff @(posedge clk_36MHz) begin
    if (!reset) begin
      state_q       <= ATTRACT;
      enable        <= 1'b0;
      clear         <= 1'b0;
      clear_score   <= 1'b0;
      active_player <= 1'b0;
      lives_p0      <= '0;
      lives_p1      <= '0;
      score_p0      <= '0;
      score_p1      <= '0;
    end else begin
      clear       <= 1'b0;
      clear_score <= 1'b0;
      case (state_q)
        ATTRACT: if (start_debounced) begin
          lives_p0 <= LIVES_W'(LIVES);
`ifdef TWO_PLAYER_EN
          lives_p1 <= LIVES_W'(LIVES);
`endif
          score_p0      <= '0;
          score_p1      <= '0;
          active_player <= 1'b0;
          clear         <= 1'b1;
          clear_score   <= 1'b1;
          state_q       <= READY;
        end
        READY: if (done) begin
          enable  <= 1'b1;
          state_q <= PLAY;
        end
        PLAY: begin
          // A hit landing in the same cycle as a ship loss still scores.
          if (hit) begin
            if (active_player) score_p1 <= score_p1 + 8'd1;
            else               score_p0 <= score_p0 + 8'd1;
          end
          if (ship_hit) begin
            if (active_player) begin
              if (lives_p1 != '0) lives_p1 <= lives_p1 - 3'd1;
            end else begin
              if (lives_p0 != '0) lives_p0 <= lives_p0 - 3'd1;
            end
            enable  <= 1'b0;
            state_q <= DYING;
          end else if (wave_cleared) begin
            enable  <= 1'b0;
            state_q <= WAVE;
          end
        end
        DYING: if (done) begin
          if (go_over) begin
            state_q <= OVER;
          end else begin
`ifdef TWO_PLAYER_EN
            if (other_alive) begin
              active_player <= ~active_player;
              clear_score   <= 1'b1;
            end
`endif
            clear   <= 1'b1;
            state_q <= READY;
          end
        end
        WAVE: if (done) begin
          clear   <= 1'b1;
          state_q <= READY;
        end
        OVER: if (done) state_q <= ATTRACT;
        default: state_q <= ATTRACT;
      endcase
    end
  end
endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: a vector table for the main game flow plus
// hand-written sequences for reset, score wrap and game-over/high-score cases.
module tb_game_controller;
  logic       clk_36MHz = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_debounced = 1'b0;
  logic       hit = 1'b0;
  logic       ship_hit = 1'b0;
  logic       wave_cleared = 1'b0;
  logic       enable, clear, clear_score, active_player;
  logic [2:0] lives, state;
  logic [7:0] score_p0, score_p1, hi_score;

  int pass_cnt = 0;
  int total_cnt = 0;

  game_controller #(.LIVES(3), .PAUSE_FRAMES(60)) dut (
    .clk_36MHz       (clk_36MHz),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .start_debounced (start_debounced),
    .hit             (hit),
    .ship_hit        (ship_hit),
    .wave_cleared    (wave_cleared),
    .enable          (enable),
    .clear           (clear),
    .clear_score     (clear_score),
    .active_player   (active_player),
    .lives           (lives),
    .state           (state),
    .score_p0        (score_p0),
    .score_p1        (score_p1),
    .hi_score        (hi_score)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  typedef struct {
    string      name;
    logic       st, h, sh, w, tk;
    int         reps;
    logic [2:0] e_state;
    logic       e_en;
    logic [2:0] e_lives;
    logic [7:0] e_s0;
    logic       e_ap;
    logic       e_clr;
    logic       e_clrs;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic s, input logic h, input logic sh, input logic w, input logic t);
    start_debounced = s; hit = h; ship_hit = sh; wave_cleared = w; frame_tick = t;
    @(posedge clk_36MHz); #1;
    start_debounced = 0; hit = 0; ship_hit = 0; wave_cleared = 0; frame_tick = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic add(input string n, input logic st, input logic h, input logic sh,
                     input logic w, input logic tk, input int reps, input logic [2:0] es,
                     input logic een, input logic [2:0] el, input logic [7:0] es0,
                     input logic eap, input logic eclr, input logic eclrs);
    vec_t v;
    v.name = n; v.st = st; v.h = h; v.sh = sh; v.w = w; v.tk = tk; v.reps = reps;
    v.e_state = es; v.e_en = een; v.e_lives = el; v.e_s0 = es0;
    v.e_ap = eap; v.e_clr = eclr; v.e_clrs = eclrs;
    vq.push_back(v);
  endtask

  initial begin
    int deaths;
    int exp_deaths;
    logic exp_ap;
    logic [2:0] exp_lv;

`ifdef TWO_PLAYER_EN
    exp_ap = 1'b1; exp_lv = 3'd3; exp_deaths = 6;
`else
    exp_ap = 1'b0; exp_lv = 3'd2; exp_deaths = 3;
`endif
    //   name            st h sh w tk reps st en lv s0 ap clr clrs
    add("hit_in_ready",  0, 1, 0, 0, 0, 1,  1, 0, 3, 0, 0, 0, 0);
    add("ready_59",      0, 0, 0, 0, 1, 59, 1, 0, 3, 0, 0, 0, 0);
    add("ready_60",      0, 0, 0, 0, 1, 1,  2, 1, 3, 0, 0, 0, 0);
    add("hit_x5",        0, 1, 0, 0, 0, 5,  2, 1, 3, 5, 0, 0, 0);
    add("ship_wave_hit", 0, 1, 1, 1, 0, 1,  3, 0, 2, 6, 0, 0, 0);
    add("hit_in_dying",  0, 1, 0, 0, 0, 1,  3, 0, 2, 6, 0, 0, 0);
    add("dying_end",     0, 0, 0, 0, 1, 60, 1, 0, exp_lv, 6, exp_ap, 1, exp_ap);
    add("ready_to_play", 0, 0, 0, 0, 1, 60, 2, 1, exp_lv, 6, exp_ap, 0, 0);
    add("wave_enter",    0, 0, 0, 1, 0, 1,  4, 0, exp_lv, 6, exp_ap, 0, 0);
    add("wave_end",      0, 0, 0, 0, 1, 60, 1, 0, exp_lv, 6, exp_ap, 1, 0);
    add("start_ignored", 1, 0, 0, 0, 0, 1,  1, 0, exp_lv, 6, exp_ap, 0, 0);

    do_reset();
    chk("rst_state", state, 0);
    chk("rst_enable", enable, 0);
    chk("rst_lives", lives, 0);
    chk("rst_score_p0", score_p0, 0);
    chk("rst_clear", clear, 0);

    cyc(1, 0, 0, 0, 0);
    chk("start_state", state, 1);
    chk("start_clear", clear, 1);
    chk("start_clear_score", clear_score, 1);
    chk("start_lives", lives, 3);
    chk("start_ap", active_player, 0);
    cyc(0, 0, 0, 0, 0);
    chk("clear_one_cycle", clear, 0);
    chk("clear_score_one_cycle", clear_score, 0);

    foreach (vq[i]) begin
      for (int r = 0; r < vq[i].reps; r++) begin
        if (vq[i].tk) cyc(0, 0, 0, 0, 0);
        cyc(vq[i].st, vq[i].h, vq[i].sh, vq[i].w, vq[i].tk);
      end
      chk({vq[i].name, "_state"}, state, vq[i].e_state);
      chk({vq[i].name, "_enable"}, enable, vq[i].e_en);
      chk({vq[i].name, "_lives"}, lives, vq[i].e_lives);
      chk({vq[i].name, "_score_p0"}, score_p0, vq[i].e_s0);
      chk({vq[i].name, "_ap"}, active_player, vq[i].e_ap);
      chk({vq[i].name, "_clear"}, clear, vq[i].e_clr);
      chk({vq[i].name, "_clear_score"}, clear_score, vq[i].e_clrs);
    end

    // Score wraps at 256, then reset in the middle of play.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    ticks(60);
    chk("wrap_in_play", state, 2);
    for (int i = 0; i < 255; i++) cyc(0, 1, 0, 0, 0);
    chk("score_255", score_p0, 255);
    cyc(0, 1, 0, 0, 0);
    chk("score_wrap", score_p0, 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("midplay_rst_state", state, 0);
    chk("midplay_rst_enable", enable, 0);
    chk("midplay_rst_clear", clear, 0);
    chk("midplay_rst_clear_score", clear_score, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // Game over with 200 points, high score retained across reset.
    cyc(1, 0, 0, 0, 0);
    ticks(60);
    for (int i = 0; i < 200; i++) cyc(0, 1, 0, 0, 0);
    chk("score_200", score_p0, 200);
    deaths = 0;
    for (int n = 0; n < 3000 && state != 3'd5; n++) begin
      if (state == 3'd2) begin
        cyc(0, 0, 1, 0, 0);
        deaths++;
      end else begin
        ticks(1);
      end
    end
    chk("over_state", state, 5);
    chk("over_deaths", deaths, exp_deaths);
    chk("over_hi_score", hi_score, 200);
    chk("over_enable", enable, 0);
    ticks(60);
    chk("over_to_attract", state, 0);
    do_reset();
    chk("hi_after_reset", hi_score, 200);
    chk("state_after_reset", state, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
